tex_column_walker: RTL and testbench

Per-column row sequencer between the DDA ray stage and the `textures` lookup stage. It accepts one column descriptor per ray: screen column, clamped line height, wallX and texture id. It then walks all SCREEN_HEIGHT rows of that column, issuing one texture request per wall row and substituting ceiling or floor colours elsewhere. Every row is written, in row order, as one framebuffer pixel after the texture ROM latency.

---
 rtl/raycast_pkg.sv | 21 ++
 rtl/tex_column_walker_if.sv | 37 +++
 rtl/tex_req_delay.sv | 52 +++++
 rtl/tex_column_walker.sv | 196 +++++++++++++++++++
 tb/tb_tex_column_walker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/raycast_pkg.sv
// rtl/raycast_pkg.sv - shared raycaster screen constants, default colours and row tag types
package raycast_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int FB_ADDR_W     = 16;

    localparam logic [15:0] DEFAULT_CEIL_COLOR  = 16'h4208;
    localparam logic [15:0] DEFAULT_FLOOR_COLOR = 16'h8410;

    typedef enum logic [1:0] {CEIL, WALL, FLOOR} row_kind_t;

    typedef enum logic [2:0] {IDLE, INIT, ROW, NORM, DRAIN} walk_state_t;

    typedef struct packed {
        row_kind_t              kind;
        logic [FB_ADDR_W-1:0]   addr;
        logic                   side;
    } row_tag_t;

endpackage

// File: rtl/tex_column_walker_if.sv
// rtl/tex_column_walker_if.sv - column descriptor, texture request and framebuffer write bundle
interface tex_column_walker_if;

    logic        col_valid_in;
    logic        col_ready_out;
    logic [8:0]  hcount_ray_in;
    logic [7:0]  line_height_in;
    logic [15:0] wallX_in;
    logic [3:0]  texture_in;
    logic        side_in;

    logic        tex_req_valid_out;
    logic [15:0] tex_wallX_out;
    logic [7:0]  tex_vcount_out;
    logic [3:0]  tex_id_out;
    logic [15:0] tex_pixel_in;

    logic        fb_we_out;
    logic [15:0] fb_addr_out;
    logic [15:0] fb_pixel_out;
    logic        busy_out;

    modport master (
        output col_valid_in, hcount_ray_in, line_height_in, wallX_in, texture_in, side_in,
        output tex_pixel_in,
        input  col_ready_out, tex_req_valid_out, tex_wallX_out, tex_vcount_out, tex_id_out,
        input  fb_we_out, fb_addr_out, fb_pixel_out, busy_out
    );

    modport slave (
        input  col_valid_in, hcount_ray_in, line_height_in, wallX_in, texture_in, side_in,
        input  tex_pixel_in,
        output col_ready_out, tex_req_valid_out, tex_wallX_out, tex_vcount_out, tex_id_out,
        output fb_we_out, fb_addr_out, fb_pixel_out, busy_out
    );

endinterface

// File: rtl/tex_req_delay.sv
// rtl/tex_req_delay.sv - fixed-latency shift register aligning row tags with texture ROM returns
module tex_req_delay
    import raycast_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     s_tvalid,
    input  row_tag_t s_tdata,
    output logic     m_tvalid,
    output row_tag_t m_tdata,
    output logic     pending
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    row_tag_t           tag_q [LATENCY];
    row_tag_t           tag_d [LATENCY];

    always_comb begin
        valid_d[0] = s_tvalid;
        tag_d[0]   = s_tdata;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
        // Anything short of the output stage still has to come out.
        pending = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign m_tvalid = valid_q[LATENCY-1];
    assign m_tdata  = tag_q[LATENCY-1];

endmodule

// File: rtl/tex_column_walker.sv
// rtl/tex_column_walker.sv - walks every row of one ray column, issuing texture requests and framebuffer writes
// Optional TEX_SHADE_EN halves RGB565 wall pixels hit on the y-side.
module tex_column_walker
    import raycast_pkg::*;
#(
    parameter int          TEX_LATENCY = 2,
    parameter logic [15:0] CEIL_COLOR  = DEFAULT_CEIL_COLOR,
    parameter logic [15:0] FLOOR_COLOR = DEFAULT_FLOOR_COLOR
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    tex_column_walker_if.slave bus
);

    localparam logic [7:0]  ROWS_LAST = 8'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]  ROWS_END  = 8'(SCREEN_HEIGHT);
    localparam logic [8:0]  ACC_STEP  = 9'(SCREEN_HEIGHT);
    localparam logic [15:0] ADDR_STEP = 16'(SCREEN_WIDTH);

    walk_state_t state_q, state_d;
    logic [8:0]  hcount_q, hcount_d;
    logic [7:0]  lh_q, lh_d;
    logic [15:0] wallx_q, wallx_d;
    logic [3:0]  tex_id_q, tex_id_d;
    logic        side_q, side_d;
    logic [7:0]  ds_q, ds_d;
    logic [7:0]  de_q, de_d;
    logic [8:0]  acc_q, acc_d;
    logic [7:0]  tex_v_q, tex_v_d;
    logic [7:0]  row_q, row_d;
    logic [15:0] addr_q, addr_d;
    logic        req_valid_q, req_valid_d;
    logic [7:0]  req_vcount_q, req_vcount_d;

    logic [8:0]  acc_sum;
    logic [8:0]  acc_diff;
    logic [7:0]  lh_clamp;
    row_kind_t   cur_kind;
    logic        push_valid;
    row_tag_t    push_tag;

    logic        out_valid;
    row_tag_t    out_tag;
    logic        pipe_pending;
    logic [15:0] wall_pixel;
    logic [15:0] out_pixel;

    always_comb begin
        state_d    = state_q;
        hcount_d   = hcount_q;
        lh_d       = lh_q;
        wallx_d    = wallx_q;
        tex_id_d   = tex_id_q;
        side_d     = side_q;
        ds_d       = ds_q;
        de_d       = de_q;
        acc_d      = acc_q;
        tex_v_d    = tex_v_q;
        row_d      = row_q;
        addr_d     = addr_q;
        acc_sum    = acc_q + ACC_STEP;
        acc_diff   = acc_q - {1'b0, lh_q};
        lh_clamp   = (lh_q > ROWS_END) ? ROWS_END : lh_q;
        cur_kind   = (row_q < ds_q) ? CEIL : ((row_q >= de_q) ? FLOOR : WALL);
        push_valid = 1'b0;
        push_tag   = '{kind: cur_kind, addr: addr_q, side: side_q};

        case (state_q)
            IDLE: begin
                if (bus.col_valid_in) begin
                    hcount_d = bus.hcount_ray_in;
                    lh_d     = bus.line_height_in;
                    wallx_d  = bus.wallX_in;
                    tex_id_d = bus.texture_in;
                    side_d   = bus.side_in;
                    state_d  = INIT;
                end
            end
            INIT: begin
                lh_d    = lh_clamp;
                ds_d    = (ROWS_END - lh_clamp) >> 1;
                de_d    = ds_d + lh_clamp;
                acc_d   = '0;
                tex_v_d = '0;
                row_d   = '0;
                addr_d  = 16'(hcount_q);
                state_d = ROW;
            end
            ROW: begin
                push_valid = 1'b1;
                row_d      = row_q + 8'd1;
                addr_d     = addr_q + ADDR_STEP;
                if (cur_kind == WALL) begin
                    acc_d = acc_sum;
                end
                if ((cur_kind == WALL) && (acc_sum >= {1'b0, lh_q})) begin
                    state_d = NORM;
                end else if (row_q == ROWS_LAST) begin
                    state_d = DRAIN;
                end
            end
            NORM: begin
                // Bresenham-style step: row_q already points past the wall row just issued.
                acc_d   = acc_diff;
                tex_v_d = tex_v_q + 8'd1;
                if (acc_diff < {1'b0, lh_q}) begin
                    state_d = (row_q == ROWS_END) ? DRAIN : ROW;
                end
            end
            DRAIN: begin
                if (!pipe_pending) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request outputs are registered for the row the FSM is about to issue.
        req_valid_d  = (state_d == ROW) && (row_d >= ds_d) && (row_d < de_d);
        req_vcount_d = req_valid_d ? tex_v_d : req_vcount_q;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            hcount_q     <= '0;
            lh_q         <= '0;
            wallx_q      <= '0;
            tex_id_q     <= '0;
            side_q       <= 1'b0;
            ds_q         <= '0;
            de_q         <= '0;
            acc_q        <= '0;
            tex_v_q      <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            req_valid_q  <= 1'b0;
            req_vcount_q <= '0;
        end else begin
            state_q      <= state_d;
            hcount_q     <= hcount_d;
            lh_q         <= lh_d;
            wallx_q      <= wallx_d;
            tex_id_q     <= tex_id_d;
            side_q       <= side_d;
            ds_q         <= ds_d;
            de_q         <= de_d;
            acc_q        <= acc_d;
            tex_v_q      <= tex_v_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            req_valid_q  <= req_valid_d;
            req_vcount_q <= req_vcount_d;
        end
    end

    tex_req_delay #(
        .LATENCY (TEX_LATENCY)
    ) u_delay (
        .clk      (pixel_clk_in),
        .rst      (rst_in),
        .s_tvalid (push_valid),
        .s_tdata  (push_tag),
        .m_tvalid (out_valid),
        .m_tdata  (out_tag),
        .pending  (pipe_pending)
    );

`ifdef TEX_SHADE_EN
    assign wall_pixel = out_tag.side ? ((bus.tex_pixel_in >> 1) & 16'h7BEF) : bus.tex_pixel_in;
`else
    logic unused_side;
    assign unused_side = out_tag.side;
    assign wall_pixel  = bus.tex_pixel_in;
`endif

    always_comb begin
        out_pixel = FLOOR_COLOR;
        case (out_tag.kind)
            CEIL:    out_pixel = CEIL_COLOR;
            WALL:    out_pixel = wall_pixel;
            default: out_pixel = FLOOR_COLOR;
        endcase
    end

    assign bus.col_ready_out     = (state_q == IDLE);
    assign bus.busy_out          = (state_q != IDLE);
    assign bus.tex_req_valid_out = req_valid_q;
    assign bus.tex_vcount_out    = req_vcount_q;
    assign bus.tex_wallX_out     = wallx_q;
    assign bus.tex_id_out        = tex_id_q;
    assign bus.fb_we_out         = out_valid;
    assign bus.fb_addr_out       = out_valid ? out_tag.addr : '0;
    assign bus.fb_pixel_out      = out_valid ? out_pixel : '0;

endmodule

// File: tb/tb_tex_column_walker.sv
// tb/tb_tex_column_walker.sv - directed self-checking bench for tex_column_walker
module tb_tex_column_walker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tex_column_walker_if bus();

    tex_column_walker #(
        .TEX_LATENCY (2),
        .CEIL_COLOR  (16'h4208),
        .FLOOR_COLOR (16'h8410)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle_ctr = 0;
    int rom_mode = 0;

    logic [15:0] rom_p1 = 16'hDEAD;
    logic [15:0] rom_p2 = 16'hDEAD;

    logic [15:0] wr_addr [$];
    logic [15:0] wr_pix  [$];
    int          wr_cyc  [$];
    logic [7:0]  rq_v    [$];
    int          rq_cyc  [$];
    logic [3:0]  rq_id   [$];
    logic [15:0] rq_wx   [$];

    always @(posedge clk) cycle_ctr <= cycle_ctr + 1;

    // Two-stage texture ROM; non-request slots return a poison value.
    always @(posedge clk) begin
        if (bus.tex_req_valid_out)
            rom_p1 <= (rom_mode == 1) ? 16'hFFFF : {8'h00, bus.tex_vcount_out};
        else
            rom_p1 <= 16'hDEAD;
        rom_p2 <= rom_p1;
    end
    assign bus.tex_pixel_in = rom_p2;

    always @(negedge clk) begin
        if (bus.fb_we_out) begin
            wr_addr.push_back(bus.fb_addr_out);
            wr_pix.push_back(bus.fb_pixel_out);
            wr_cyc.push_back(cycle_ctr);
        end
        if (bus.tex_req_valid_out) begin
            rq_v.push_back(bus.tex_vcount_out);
            rq_cyc.push_back(cycle_ctr);
            rq_id.push_back(bus.tex_id_out);
            rq_wx.push_back(bus.tex_wallX_out);
        end
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_pix.delete(); wr_cyc.delete();
        rq_v.delete(); rq_cyc.delete(); rq_id.delete(); rq_wx.delete();
    endtask

    task automatic run_column(input logic [8:0] hc, input logic [7:0] lh, input logic [15:0] wx,
                              input logic [3:0] tid, input logic sd, output int t0, output int rdy);
        @(negedge clk);
        clear_logs();
        bus.hcount_ray_in  = hc;
        bus.line_height_in = lh;
        bus.wallX_in       = wx;
        bus.texture_in     = tid;
        bus.side_in        = sd;
        bus.col_valid_in   = 1'b1;
        t0 = cycle_ctr;
        @(negedge clk);
        bus.col_valid_in = 1'b0;
        rdy = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus.col_ready_out) begin
                rdy = cycle_ctr - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.col_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.col_ready_out); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_out); end
        checks++; if (bus.fb_we_out !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b expected 0", bus.fb_we_out); end
        checks++; if (bus.tex_req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.tex_req_valid_out); end
        checks++; if (bus.fb_addr_out !== 16'h0 || bus.fb_pixel_out !== 16'h0) begin errors++; $display("FAIL reset_fb_bus: got addr %h pixel %h expected 0 0", bus.fb_addr_out, bus.fb_pixel_out); end
        checks++; if (bus.tex_vcount_out !== 8'h0 || bus.tex_id_out !== 4'h0 || bus.tex_wallX_out !== 16'h0) begin errors++; $display("FAIL reset_tex_bus: got v %h id %h wx %h expected 0", bus.tex_vcount_out, bus.tex_id_out, bus.tex_wallX_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_wall();
        int t0, rdy;
        logic [15:0] ea, ep;
        run_column(9'd5, 8'd0, 16'h0042, 4'd4, 1'b0, t0, rdy);
        checks++; if (rdy != 184) begin errors++; $display("FAIL no_wall_ready: got %0d expected 184", rdy); end
        checks++; if (rq_v.size() != 0) begin errors++; $display("FAIL no_wall_reqs: got %0d expected 0", rq_v.size()); end
        checks++; if (wr_addr.size() != 180) begin errors++; $display("FAIL no_wall_writes: got %0d expected 180", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 180; i++) begin
            ea = 16'(5 + 320 * i);
            ep = (i < 90) ? 16'h4208 : 16'h8410;
            checks++;
            if (wr_addr[i] !== ea || wr_pix[i] !== ep || (wr_cyc[i] - t0) != 4 + i) begin
                errors++;
                $display("FAIL no_wall_row%0d: got addr %0d pix %h cyc %0d expected %0d %h %0d", i, wr_addr[i], wr_pix[i], wr_cyc[i] - t0, ea, ep, 4 + i);
            end
        end
    endtask

    task automatic test_wall_90();
        int t0, rdy, ec;
        logic [15:0] ea, ep;
        rom_mode = 0;
        run_column(9'd0, 8'd90, 16'hA5C3, 4'd3, 1'b0, t0, rdy);
        checks++; if (rdy != 364) begin errors++; $display("FAIL wall90_ready: got %0d expected 364", rdy); end
        checks++; if (rq_v.size() != 90) begin errors++; $display("FAIL wall90_reqs: got %0d expected 90", rq_v.size()); end
        for (int j = 0; j < rq_v.size() && j < 90; j++) begin
            checks++;
            if (rq_v[j] !== 8'(2 * j) || rq_id[j] !== 4'd3 || rq_wx[j] !== 16'hA5C3 || (rq_cyc[j] - t0) != 47 + 3 * j) begin
                errors++;
                $display("FAIL wall90_req%0d: got v %0d id %0d wx %h cyc %0d expected %0d 3 a5c3 %0d", j, rq_v[j], rq_id[j], rq_wx[j], rq_cyc[j] - t0, 2 * j, 47 + 3 * j);
            end
        end
        checks++; if (wr_addr.size() != 180) begin errors++; $display("FAIL wall90_writes: got %0d expected 180", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 180; i++) begin
            ea = 16'(320 * i);
            if (i < 45) begin ep = 16'h4208; ec = 4 + i; end
            else if (i < 135) begin ep = {8'h00, 8'(2 * (i - 45))}; ec = 49 + 3 * (i - 45); end
            else begin ep = 16'h8410; ec = 184 + i; end
            checks++;
            if (wr_addr[i] !== ea || wr_pix[i] !== ep || (wr_cyc[i] - t0) != ec) begin
                errors++;
                $display("FAIL wall90_row%0d: got addr %0d pix %h cyc %0d expected %0d %h %0d", i, wr_addr[i], wr_pix[i], wr_cyc[i] - t0, ea, ep, ec);
            end
        end
    endtask

    task automatic test_clamp();
        int t0, rdy;
        logic [15:0] ea, ep;
        rom_mode = 0;
        run_column(9'd319, 8'd200, 16'h0007, 4'd5, 1'b0, t0, rdy);
        checks++; if (rdy != 363) begin errors++; $display("FAIL clamp_ready: got %0d expected 363", rdy); end
        checks++; if (rq_v.size() != 180) begin errors++; $display("FAIL clamp_reqs: got %0d expected 180", rq_v.size()); end
        for (int j = 0; j < rq_v.size() && j < 180; j++) begin
            checks++;
            if (rq_v[j] !== 8'(j) || (rq_cyc[j] - t0) != 2 + 2 * j) begin
                errors++;
                $display("FAIL clamp_req%0d: got v %0d cyc %0d expected %0d %0d", j, rq_v[j], rq_cyc[j] - t0, j, 2 + 2 * j);
            end
        end
        checks++; if (wr_addr.size() != 180) begin errors++; $display("FAIL clamp_writes: got %0d expected 180", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 180; i++) begin
            ea = 16'(319 + 320 * i);
            ep = {8'h00, 8'(i)};
            checks++;
            if (wr_addr[i] !== ea || wr_pix[i] !== ep || (wr_cyc[i] - t0) != 4 + 2 * i) begin
                errors++;
                $display("FAIL clamp_row%0d: got addr %0d pix %h cyc %0d expected %0d %h %0d", i, wr_addr[i], wr_pix[i], wr_cyc[i] - t0, ea, ep, 4 + 2 * i);
            end
        end
    endtask

    task automatic test_busy_reset();
        int t0, rdy;
        @(negedge clk);
        clear_logs();
        bus.hcount_ray_in  = 9'd7;
        bus.line_height_in = 8'd90;
        bus.wallX_in       = 16'h0011;
        bus.texture_in     = 4'd4;
        bus.side_in        = 1'b0;
        bus.col_valid_in   = 1'b1;
        t0 = cycle_ctr;
        @(negedge clk);
        bus.hcount_ray_in = 9'd9;
        bus.line_height_in = 8'd0;
        for (int n = 0; n < 200 && (cycle_ctr - t0) < 62; n++) begin
            @(negedge clk);
            if (cycle_ctr - t0 == 30) begin
                checks++;
                if (bus.col_ready_out !== 1'b0 || bus.busy_out !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_hold: got ready %b busy %b expected 0 1", bus.col_ready_out, bus.busy_out);
                end
            end
        end
        rst = 1'b1;
        bus.col_valid_in = 1'b0;
        #1;
        checks++; if (bus.col_ready_out !== 1'b1 || bus.fb_we_out !== 1'b0) begin errors++; $display("FAIL midreset_state: got ready %b we %b expected 1 0", bus.col_ready_out, bus.fb_we_out); end
        checks++; if (wr_addr.size() != 50) begin errors++; $display("FAIL midreset_partial: got %0d writes expected 50", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 50; i++) begin
            checks++;
            if (wr_addr[i] !== 16'(7 + 320 * i)) begin
                errors++;
                $display("FAIL midreset_addr%0d: got %0d expected %0d", i, wr_addr[i], 7 + 320 * i);
            end
        end
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) @(negedge clk);
        checks++; if (wr_addr.size() != 0 || rq_v.size() != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d writes %0d reqs expected 0 0", wr_addr.size(), rq_v.size()); end
        run_column(9'd9, 8'd0, 16'h0000, 4'd3, 1'b0, t0, rdy);
        checks++; if (rdy != 184) begin errors++; $display("FAIL after_reset_ready: got %0d expected 184", rdy); end
        checks++; if (wr_addr.size() != 180) begin errors++; $display("FAIL after_reset_writes: got %0d expected 180", wr_addr.size()); end
        if (wr_addr.size() == 180) begin
            checks++; if (wr_addr[0] !== 16'd9 || wr_addr[179] !== 16'd57289) begin errors++; $display("FAIL after_reset_addr: got %0d %0d expected 9 57289", wr_addr[0], wr_addr[179]); end
        end
    endtask

    task automatic test_shade();
        int t0, rdy;
        logic [15:0] ew;
`ifdef TEX_SHADE_EN
        ew = 16'h7BEF;
`else
        ew = 16'hFFFF;
`endif
        rom_mode = 1;
        run_column(9'd2, 8'd90, 16'h0033, 4'd5, 1'b1, t0, rdy);
        checks++; if (rdy != 364) begin errors++; $display("FAIL shade_ready: got %0d expected 364", rdy); end
        checks++; if (wr_addr.size() != 180) begin errors++; $display("FAIL shade_writes: got %0d expected 180", wr_addr.size()); end
        if (wr_addr.size() == 180) begin
            checks++; if (wr_pix[10] !== 16'h4208) begin errors++; $display("FAIL shade_ceil: got %h expected 4208", wr_pix[10]); end
            checks++; if (wr_pix[45] !== ew) begin errors++; $display("FAIL shade_wall_first: got %h expected %h", wr_pix[45], ew); end
            checks++; if (wr_pix[134] !== ew) begin errors++; $display("FAIL shade_wall_last: got %h expected %h", wr_pix[134], ew); end
            checks++; if (wr_pix[170] !== 16'h8410) begin errors++; $display("FAIL shade_floor: got %h expected 8410", wr_pix[170]); end
        end
        rom_mode = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.col_valid_in   = 1'b0;
        bus.hcount_ray_in  = '0;
        bus.line_height_in = '0;
        bus.wallX_in       = '0;
        bus.texture_in     = '0;
        bus.side_in        = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_no_wall();
        test_wall_90();
        test_clamp();
        test_busy_reset();
        test_shade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
